// File: rtl/dcf77_frame_encoder.sv
// DCF77 minute-frame pulse generator driven by BCD time/date inputs.
// Optional `DCF77_ERR_INJECT_EN adds inject_err_i to invert the minute parity bit (bit 28).
// state  | meaning
// S_IDLE | not transmitting; latches inputs and starts second 0 when enable_i rises
// S_RUN  | counting prescaler/ms/seconds and emitting pulses from the shadow frame
module dcf77_frame_encoder #(
  parameter int TICKS_PER_MS = 50000,
  parameter int PULSE0_MS    = 100,
  parameter int PULSE1_MS    = 200
) (
  input  logic       qzt_clk_i,
  input  logic       reset_i,
  input  logic       enable_i,
  input  logic [6:0] minute_i,
  input  logic [5:0] hour_i,
  input  logic [5:0] day_i,
  input  logic [2:0] weekday_i,
  input  logic [4:0] month_i,
  input  logic [7:0] year_i,
  input  logic       cest_i,
`ifdef DCF77_ERR_INJECT_EN
  input  logic       inject_err_i,
`endif
  output logic       dcf_out_o,
  output logic [5:0] sec_count_o,
  output logic       frame_start_o,
  output logic       busy_o
);

  localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_MS - 1);
  localparam logic [9:0]    MS_LAST  = 10'd999;
  localparam logic [9:0]    P0_MS    = 10'(PULSE0_MS);
  localparam logic [9:0]    P1_MS    = 10'(PULSE1_MS);
  localparam logic [5:0]    SEC_LAST = 6'd59;

  typedef enum logic [0:0] {S_IDLE, S_RUN} state_t;

  state_t        state_q;
  logic          busy_q;
  logic          dcf_q;
  logic          frame_start_q;
  logic [5:0]    sec_q;
  logic [9:0]    ms_q;
  logic [PW-1:0] pre_q;
  logic [58:0]   shadow_q;
  logic [58:0]   frame_d;
  logic [63:0]   frame_ext;
  logic          inj;
  logic          cur_bit;
  logic          pulse_on;

`ifdef DCF77_ERR_INJECT_EN
  assign inj = inject_err_i;
`else
  assign inj = 1'b0;
`endif

  always_comb begin
    frame_d        = '0;
    frame_d[17]    = cest_i;
    frame_d[18]    = ~cest_i;
    frame_d[20]    = 1'b1;
    frame_d[27:21] = minute_i;
    frame_d[28]    = (^minute_i) ^ inj;
    frame_d[34:29] = hour_i;
    frame_d[35]    = ^hour_i;
    frame_d[41:36] = day_i;
    frame_d[44:42] = weekday_i;
    frame_d[49:45] = month_i;
    frame_d[57:50] = year_i;
    frame_d[58]    = ^{year_i, month_i, weekday_i, day_i};
  end

  // Zero-extended so second 59 indexes a defined (always-0) bit.
  assign frame_ext = {5'b0, shadow_q};
  assign cur_bit   = frame_ext[sec_q];
  assign pulse_on  = (sec_q != SEC_LAST) && (ms_q < (cur_bit ? P1_MS : P0_MS));

  always_ff @(posedge qzt_clk_i) begin
    if (reset_i) begin
      state_q       <= S_IDLE;
      busy_q        <= 1'b0;
      dcf_q         <= 1'b0;
      frame_start_q <= 1'b0;
      sec_q         <= '0;
      ms_q          <= '0;
      pre_q         <= '0;
      shadow_q      <= '0;
    end else begin
      frame_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          dcf_q <= 1'b0;
          if (enable_i) begin
            shadow_q      <= frame_d;
            state_q       <= S_RUN;
            busy_q        <= 1'b1;
            frame_start_q <= 1'b1;
            sec_q         <= '0;
            ms_q          <= '0;
            pre_q         <= '0;
          end
        end
        S_RUN: begin
          if (!enable_i) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            dcf_q   <= 1'b0;
            sec_q   <= '0;
            ms_q    <= '0;
            pre_q   <= '0;
          end else begin
            dcf_q <= pulse_on;
            if (pre_q == PRE_LAST) begin
              pre_q <= '0;
              if (ms_q == MS_LAST) begin
                ms_q <= '0;
                if (sec_q == SEC_LAST) begin
                  sec_q         <= '0;
                  shadow_q      <= frame_d;
                  frame_start_q <= 1'b1;
                end else begin
                  sec_q <= sec_q + 6'd1;
                end
              end else begin
                ms_q <= ms_q + 10'd1;
              end
            end else begin
              pre_q <= pre_q + 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dcf_out_o     = dcf_q;
  assign sec_count_o   = sec_q;
  assign frame_start_o = frame_start_q;
  assign busy_o        = busy_q;

endmodule
